// File: rtl/key_debounce_repeat_pkg.sv
// Shared types and helpers for the key debounce / auto-repeat stage.
package key_debounce_repeat_pkg;

    // Key FSM state encodings.
    typedef enum logic [1:0] {
        StReleased  = 2'd0,
        StHeld      = 2'd1,
        StRepeating = 2'd2
    } key_state_e;

    // Bits needed for a counter that runs 0 .. max_val-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with a configurable reset value.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_debounce_repeat.sv
// Push-button conditioner: synchronise, debounce, press/release pulses and auto-repeat.
module key_debounce_repeat
    import key_debounce_repeat_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 50000,
    parameter int unsigned HOLD_CYCLES    = 5000000,
    parameter int unsigned REPEAT_CYCLES  = 1000000,
    parameter bit          REPEAT_EN      = 1'b1,
    parameter bit          ACTIVE_LOW_KEY = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic key_pulse
);

    localparam int unsigned StabW = cnt_width(STABLE_CYCLES);
    localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);
    localparam int unsigned RepW  = cnt_width(REPEAT_CYCLES);

    localparam logic [StabW-1:0] StabLast = StabW'(STABLE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [RepW-1:0]  RepLast  = RepW'(REPEAT_CYCLES - 1);

    logic             key_sync;
    logic             key_s;
    logic             level_q, level_d;
    logic [StabW-1:0] stab_q, stab_d;
    logic             rise, fall;
    key_state_e       state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [RepW-1:0]  rep_q, rep_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic             key_pulse_q;

    // Reset value is the idle (unpressed) raw level so reset never looks like a press.
    sync_2ff #(
        .RESET_VAL(ACTIVE_LOW_KEY)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (key_raw),
        .q    (key_sync)
    );

    assign key_s = key_sync ^ ACTIVE_LOW_KEY;

    // Stability filter: accept a new level after STABLE_CYCLES consecutive differing samples.
    always_comb begin
        level_d = level_q;
        stab_d  = '0;
        if (key_s != level_q) begin
            if (stab_q == StabLast) begin
                level_d = key_s;
            end else begin
                stab_d = stab_q + StabW'(1);
            end
        end
    end

    // Edges of the debounced level, seen in the same cycle the level register updates.
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // Key FSM, hold/repeat timers and pulse generation; release wins over a due repeat.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        unique case (state_q)
            StReleased: begin
                hold_d = '0;
                rep_d  = '0;
                if (rise) begin
                    state_d = StHeld;
                    press_d = 1'b1;
                end
            end
            StHeld: begin
                if (fall) begin
                    state_d   = StReleased;
                    release_d = 1'b1;
                    hold_d    = '0;
                    rep_d     = '0;
                end else if (hold_q == HoldLast) begin
                    // Without repeat the timer simply parks at its last value.
                    if (REPEAT_EN) begin
                        state_d  = StRepeating;
                        repeat_d = 1'b1;
                        hold_d   = '0;
                        rep_d    = '0;
                    end
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StRepeating: begin
                if (fall) begin
                    state_d   = StReleased;
                    release_d = 1'b1;
                    hold_d    = '0;
                    rep_d     = '0;
                end else if (rep_q == RepLast) begin
                    repeat_d = 1'b1;
                    rep_d    = '0;
                end else begin
                    rep_d = rep_q + RepW'(1);
                end
            end
            default: begin
                state_d = StReleased;
                hold_d  = '0;
                rep_d   = '0;
            end
        endcase
    end

    // All state and registered pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q     <= 1'b0;
            stab_q      <= '0;
            state_q     <= StReleased;
            hold_q      <= '0;
            rep_q       <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
            key_pulse_q <= 1'b0;
        end else begin
            level_q     <= level_d;
            stab_q      <= stab_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            rep_q       <= rep_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
            key_pulse_q <= press_d | repeat_d;
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign key_pulse     = key_pulse_q;

endmodule
